// File: rtl/bsg_fsb_channel_mux.sv
// FSB client node tunnelling num_chan_p valid/yumi channels with per-channel credits.
// Optional idle credit flush: define BSG_FSB_CHANNEL_MUX_CREDIT_FLUSH_EN.
module bsg_fsb_channel_mux #(
    parameter int num_chan_p       = 2,
    parameter int width_p          = 64,
    parameter int remote_credits_p = 16,
    parameter int credit_batch_p   = 4,
    parameter int dest_id_p        = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          fsb_node_v_i,
    input  logic [79:0]                   fsb_node_data_i,
    output logic                          fsb_node_yumi_o,
    output logic                          fsb_node_v_o,
    output logic [79:0]                   fsb_node_data_o,
    input  logic                          fsb_node_yumi_i,
    input  logic [num_chan_p-1:0]         v_i,
    input  logic [num_chan_p*width_p-1:0] data_i,
    output logic [num_chan_p-1:0]         yumi_o,
    output logic [num_chan_p-1:0]         v_o,
    output logic [num_chan_p*width_p-1:0] data_o,
    input  logic [num_chan_p-1:0]         yumi_i,
    output logic                          error_o
);
    localparam int tag_w  = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int cw     = $clog2(remote_credits_p + 1);
    localparam int pw     = (remote_credits_p > 1) ? $clog2(remote_credits_p) : 1;
    localparam int flag_b = width_p + tag_w;

    function automatic logic [79:0] mk_pkt(input logic flag, input logic [tag_w-1:0] tag,
                                           input logic [width_p-1:0] data);
        logic [74:0] pl;
        pl                   = '0;
        pl[width_p-1:0]      = data;
        pl[width_p +: tag_w] = tag;
        pl[flag_b]           = flag;
        return {4'(dest_id_p), 1'b0, pl};
    endfunction

    function automatic int rr_idx(input logic [tag_w-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= num_chan_p) s = s - num_chan_p;
        return s;
    endfunction

    function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
        return (32'(p) == 32'(remote_credits_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // receive decode
    logic              rx_cmd, rx_flag, rx_bad_tag, rx_ok;
    logic [tag_w-1:0]  rx_tag;
    logic [31:0]       rx_tag32;
    logic [cw-1:0]     rx_cnt;
    logic              unused_rx;

    assign rx_cmd          = fsb_node_data_i[75];
    assign rx_flag         = fsb_node_data_i[flag_b];
    assign rx_tag          = fsb_node_data_i[width_p +: tag_w];
    assign rx_tag32        = 32'(rx_tag);
    assign rx_cnt          = fsb_node_data_i[cw-1:0];
    assign rx_bad_tag      = fsb_node_v_i & ~rx_cmd & (rx_tag32 >= 32'(num_chan_p));
    assign rx_ok           = fsb_node_v_i & ~rx_cmd & ~rx_bad_tag;
    assign fsb_node_yumi_o = fsb_node_v_i;
    assign unused_rx       = ^fsb_node_data_i;

    logic [num_chan_p-1:0]         push, push_full, pop, elig, creq, credit_ovf, credit_send;
    logic [num_chan_p-1:0][cw-1:0] pend_vec;

    for (genvar i = 0; i < num_chan_p; i++) begin : g_chan
        logic [cw-1:0]      credit_q, credit_d, pending_q, pending_d, cnt_q, cnt_d;
        logic [pw-1:0]      rd_q, wr_q;
        logic [width_p-1:0] mem_q [remote_credits_p];
        logic [cw:0]        csum;
        logic               hit, add, full;

        assign hit  = rx_ok & (rx_tag32 == 32'(i));
        assign add  = hit & rx_flag;
        assign full = (cnt_q == cw'(remote_credits_p));

        assign push[i]      = hit & ~rx_flag & ~full;
        assign push_full[i] = hit & ~rx_flag & full;
        assign v_o[i]       = (cnt_q != '0);
        assign pop[i]       = yumi_i[i] & v_o[i];
        assign data_o[i*width_p +: width_p] = mem_q[rd_q];
        assign elig[i]      = v_i[i] & (credit_q != '0);
        assign pend_vec[i]  = pending_q;

        // saturate the incoming credit first, then charge this cycle's send
        assign csum          = {1'b0, credit_q} + (add ? {1'b0, rx_cnt} : '0);
        assign credit_ovf[i] = (csum > (cw+1)'(remote_credits_p));
        assign credit_d      = (credit_ovf[i] ? cw'(remote_credits_p) : csum[cw-1:0])
                               - cw'(yumi_o[i]);
        assign pending_d     = credit_send[i] ? cw'(pop[i]) : pending_q + cw'(pop[i]);
        assign cnt_d         = cnt_q + cw'(push[i]) - cw'(pop[i]);

`ifdef BSG_FSB_CHANNEL_MUX_CREDIT_FLUSH_EN
        logic [3:0] idle_q;
        logic       idle_cond;
        assign idle_cond = ~v_o[i] & (pending_q != '0) & (pending_q < cw'(credit_batch_p));
        assign creq[i]   = (pending_q >= cw'(credit_batch_p)) | (idle_cond & (idle_q == 4'hF));

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)                                            idle_q <= '0;
            else if (push[i] | pop[i] | credit_send[i] | ~idle_cond) idle_q <= '0;
            else if (idle_q != 4'hF)                                idle_q <= idle_q + 4'd1;
        end
`else
        assign creq[i] = (pending_q >= cw'(credit_batch_p));
`endif

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                credit_q  <= cw'(remote_credits_p);
                pending_q <= '0;
                cnt_q     <= '0;
                rd_q      <= '0;
                wr_q      <= '0;
            end else begin
                credit_q  <= credit_d;
                pending_q <= pending_d;
                cnt_q     <= cnt_d;
                if (push[i]) wr_q <= ptr_inc(wr_q);
                if (pop[i])  rd_q <= ptr_inc(rd_q);
            end
        end

        always_ff @(posedge clk_i) begin
            if (push[i]) mem_q[wr_q] <= fsb_node_data_i[width_p-1:0];
        end
    end

    // output slot and arbitration
    logic             slot_v_q, slot_v_d, err_q, err_d, found;
    logic [79:0]      slot_data_q, slot_data_d;
    logic [tag_w-1:0] rr_q, rr_d;

    always_comb begin
        slot_v_d    = slot_v_q;
        slot_data_d = slot_data_q;
        rr_d        = rr_q;
        yumi_o      = '0;
        credit_send = '0;
        found       = 1'b0;
        if (slot_v_q & fsb_node_yumi_i) slot_v_d = 1'b0;
        if (~slot_v_q | fsb_node_yumi_i) begin
            for (int i = 0; i < num_chan_p; i++) begin
                if (!found && creq[i]) begin
                    found          = 1'b1;
                    credit_send[i] = 1'b1;
                    slot_v_d       = 1'b1;
                    slot_data_d    = mk_pkt(1'b1, tag_w'(i), width_p'(pend_vec[i]));
                end
            end
            for (int k = 0; k < num_chan_p; k++) begin
                for (int j = 0; j < num_chan_p; j++) begin
                    if (!found && elig[j] && (j == rr_idx(rr_q, k))) begin
                        found       = 1'b1;
                        yumi_o[j]   = 1'b1;
                        slot_v_d    = 1'b1;
                        rr_d        = tag_w'(rr_idx(tag_w'(j), 1));
                        slot_data_d = mk_pkt(1'b0, tag_w'(j), data_i[j*width_p +: width_p]);
                    end
                end
            end
        end
    end

    assign err_d = err_q | rx_bad_tag | (|push_full) | (|credit_ovf);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            slot_v_q    <= 1'b0;
            slot_data_q <= '0;
            rr_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_data_q <= slot_data_d;
            rr_q        <= rr_d;
            err_q       <= err_d;
        end
    end

    assign fsb_node_v_o    = slot_v_q;
    assign fsb_node_data_o = slot_data_q;
    assign error_o         = err_q;

endmodule

// File: tb/tb_bsg_fsb_channel_mux.sv
// Bench for bsg_fsb_channel_mux: queue-based model checked every cycle plus directed literals.
module tb_bsg_fsb_channel_mux;
    logic         clk = 1'b0;
    logic         rst;
    logic         fsb_v_i, fsb_yumi_o, fsb_v_o, fsb_yumi_i, error_o;
    logic [79:0]  fsb_d_i, fsb_d_o;
    logic [1:0]   v_i, yumi_o, v_o, yumi_i;
    logic [127:0] data_i, data_o;

    logic         f3_v, d3_error;
    logic [79:0]  f3_d;
    logic [2:0]   d3_v_o;
    logic         d3_unused_yumi_o, d3_unused_v_o;
    logic [79:0]  d3_unused_data_o;
    logic [2:0]   d3_unused_yumi;
    logic [191:0] d3_unused_chan_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_fsb_channel_mux u_dut (
        .clk_i(clk), .reset_i(rst),
        .fsb_node_v_i(fsb_v_i), .fsb_node_data_i(fsb_d_i), .fsb_node_yumi_o(fsb_yumi_o),
        .fsb_node_v_o(fsb_v_o), .fsb_node_data_o(fsb_d_o), .fsb_node_yumi_i(fsb_yumi_i),
        .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .error_o(error_o)
    );

    bsg_fsb_channel_mux #(.num_chan_p(3)) u_dut3 (
        .clk_i(clk), .reset_i(rst),
        .fsb_node_v_i(f3_v), .fsb_node_data_i(f3_d), .fsb_node_yumi_o(d3_unused_yumi_o),
        .fsb_node_v_o(d3_unused_v_o), .fsb_node_data_o(d3_unused_data_o), .fsb_node_yumi_i(1'b1),
        .v_i(3'b000), .data_i(192'd0), .yumi_o(d3_unused_yumi),
        .v_o(d3_v_o), .data_o(d3_unused_chan_data), .yumi_i(3'b000), .error_o(d3_error)
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [79:0] mk(input logic flag, input logic tag, input logic [63:0] d);
        return {4'd0, 1'b0, 9'd0, flag, tag, d};
    endfunction

    // ---------------- behavioural model ----------------
    logic [63:0] m_fq [2][$];
    int          m_cred [2];
    int          m_pend [2];
    int          m_idle [2];
    int          m_rr;
    logic        m_slot_v, m_err;
    logic [79:0] m_slot_d;

    function automatic logic m_creq(input int i);
        logic r;
        r = (m_pend[i] >= 4);
`ifdef BSG_FSB_CHANNEL_MUX_CREDIT_FLUSH_EN
        if (m_fq[i].size() == 0 && m_pend[i] > 0 && m_pend[i] < 4 && m_idle[i] >= 15) r = 1'b1;
`endif
        return r;
    endfunction

    // returns the channel getting a credit packet and the data winner (-1 = none)
    function automatic void decide(output int cch, output int dch);
        cch = -1;
        dch = -1;
        if (!m_slot_v || fsb_yumi_i) begin
            for (int i = 0; i < 2; i++) if (cch < 0 && m_creq(i)) cch = i;
            if (cch < 0)
                for (int k = 0; k < 2; k++) begin
                    int c;
                    c = (m_rr + k) % 2;
                    if (dch < 0 && v_i[c[0]] && m_cred[c] > 0) dch = c;
                end
        end
    endfunction

    int   s_cch, s_dch, s_tag, s_sum;
    int   s_pre [2];
    logic s_pop [2];
    logic s_push [2];
    logic s_cond [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_fq[i].delete();
                m_cred[i] = 16;
                m_pend[i] = 0;
                m_idle[i] = 0;
            end
            m_rr = 0; m_slot_v = 1'b0; m_slot_d = '0; m_err = 1'b0;
        end else begin
            decide(s_cch, s_dch);
            for (int i = 0; i < 2; i++) begin
                s_pre[i]  = m_fq[i].size();
                s_cond[i] = (s_pre[i] == 0) && m_pend[i] > 0 && m_pend[i] < 4;
                s_pop[i]  = yumi_i[i] && s_pre[i] > 0;
                s_push[i] = 1'b0;
                if (s_pop[i]) void'(m_fq[i].pop_front());
            end
            if (fsb_v_i && !fsb_d_i[75]) begin
                s_tag = fsb_d_i[64] ? 1 : 0;
                if (fsb_d_i[65]) begin
                    s_sum = m_cred[s_tag] + int'(fsb_d_i[15:0]);
                    if (s_sum > 16) begin m_err = 1'b1; s_sum = 16; end
                    m_cred[s_tag] = s_sum;
                end else if (s_pre[s_tag] == 16) m_err = 1'b1;
                else begin
                    m_fq[s_tag].push_back(fsb_d_i[63:0]);
                    s_push[s_tag] = 1'b1;
                end
            end
            if (s_cch >= 0) begin
                m_slot_v = 1'b1;
                m_slot_d = mk(1'b1, s_cch == 1, 64'(m_pend[s_cch]));
            end else if (s_dch >= 0) begin
                m_slot_v = 1'b1;
                m_slot_d = mk(1'b0, s_dch == 1, (s_dch == 1) ? data_i[127:64] : data_i[63:0]);
                m_cred[s_dch] = m_cred[s_dch] - 1;
                m_rr = (s_dch + 1) % 2;
            end else if (m_slot_v && fsb_yumi_i) m_slot_v = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (s_cch == i) m_pend[i] = s_pop[i] ? 1 : 0;
                else if (s_pop[i]) m_pend[i] = m_pend[i] + 1;
                if (s_push[i] || s_pop[i] || s_cch == i || !s_cond[i]) m_idle[i] = 0;
                else if (m_idle[i] < 15) m_idle[i] = m_idle[i] + 1;
            end
        end
    end

    int         c_cch, c_dch;
    logic [1:0] c_y;

    always @(negedge clk) begin
        if (!rst) begin
            decide(c_cch, c_dch);
            c_y = (c_dch == 0) ? 2'b01 : (c_dch == 1) ? 2'b10 : 2'b00;
            chk("yumi_o", 80'(yumi_o), 80'(c_y));
            chk("fsb_v_o", 80'(fsb_v_o), 80'(m_slot_v));
            if (m_slot_v) chk("fsb_data_o", fsb_d_o, m_slot_d);
            chk("fsb_yumi_o", 80'(fsb_yumi_o), 80'(fsb_v_i));
            chk("error_o", 80'(error_o), 80'(m_err));
            chk("v_o0", 80'(v_o[0]), 80'(m_fq[0].size() > 0));
            chk("v_o1", 80'(v_o[1]), 80'(m_fq[1].size() > 0));
            if (m_fq[0].size() > 0) chk("data_o0", 80'(data_o[63:0]), 80'(m_fq[0][0]));
            if (m_fq[1].size() > 0) chk("data_o1", 80'(data_o[127:64]), 80'(m_fq[1][0]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [79:0] p);
        tick();
        fsb_v_i = 1'b1;
        fsb_d_i = p;
        tick();
        fsb_v_i = 1'b0;
    endtask

    int          n, ncred;
    logic [79:0] cpkt, p;
    logic [1:0]  seq [8];
    logic [1:0]  exp_seq [8];

    initial begin
        exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
        rst = 1'b1; fsb_v_i = 1'b0; fsb_d_i = '0; fsb_yumi_i = 1'b0;
        v_i = '0; data_i = '0; yumi_i = '0; f3_v = 1'b0; f3_d = '0;
        #2;
        chk("rst_fsb_v", 80'(fsb_v_o), 80'd0);
        chk("rst_fsb_data", fsb_d_o, 80'd0);
        chk("rst_yumi", 80'(yumi_o), 80'd0);
        chk("rst_v_o", 80'(v_o), 80'd0);
        chk("rst_err", 80'(error_o), 80'd0);
        #20 rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_fsb_v", 80'(fsb_v_o), 80'd0);
        end

        // single send on channel 1
        tick(); v_i = 2'b10; data_i[127:64] = 64'hDEAD_BEEF;
        @(negedge clk); chk("single_yumi", 80'(yumi_o), 80'(2'b10));
        tick(); v_i = 2'b00;
        @(negedge clk);
        chk("single_v", 80'(fsb_v_o), 80'd1);
        chk("single_pkt", fsb_d_o, 80'h0001_0000_0000_DEAD_BEEF);
        tick(); fsb_yumi_i = 1'b1;

        // credit exhaustion on channel 0, then refill by 4
        tick(); v_i = 2'b01; data_i[63:0] = 64'h1234;
        n = 0;
        repeat (20) begin @(negedge clk); if (yumi_o[0]) n++; end
        chk("exhaust_cnt", 80'(n), 80'd16);
        inject(mk(1'b1, 1'b0, 64'd4));
        n = 0;
        repeat (10) begin @(negedge clk); if (yumi_o[0]) n++; end
        chk("refill_cnt", 80'(n), 80'd4);
        tick(); v_i = 2'b00;

        // more channel-0 credits, then 4 packets into channel 1
        inject(mk(1'b1, 1'b0, 64'd8));
        for (int k = 0; k < 4; k++) inject(mk(1'b0, 1'b1, 64'h100 + 64'(k)));
        @(negedge clk);
        chk("rx_v_o", 80'(v_o), 80'(2'b10));
        chk("rx_head", 80'(data_o[127:64]), 80'h100);

        // round-robin with draining channel 1; credit packet preempts a grant
        tick(); v_i = 2'b11; yumi_i = 2'b10;
        ncred = 0; cpkt = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) seq[c] = yumi_o;
            if (fsb_v_o && fsb_d_o[65]) begin ncred++; cpkt = fsb_d_o; end
        end
        tick(); v_i = 2'b00; yumi_i = 2'b00;
        for (int c = 0; c < 8; c++) chk("rr_seq", 80'(seq[c]), 80'(exp_seq[c]));
        chk("credit_pkts", 80'(ncred), 80'd1);
        chk("credit_pkt", cpkt, 80'h0003_0000_0000_0000_0004);

        // cmd packet is dropped; FIFO overflow sets a sticky error
        p = mk(1'b0, 1'b0, 64'h77); p[75] = 1'b1;
        inject(p);
        for (int k = 0; k < 16; k++) inject(mk(1'b0, 1'b0, 64'h200 + 64'(k)));
        @(negedge clk);
        chk("err_before", 80'(error_o), 80'd0);
        inject(mk(1'b0, 1'b0, 64'h2FF));
        @(negedge clk);
        chk("err_overflow", 80'(error_o), 80'd1);
        repeat (10) tick();
        @(negedge clk);
        chk("err_sticky", 80'(error_o), 80'd1);

        // asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        chk("arst_err", 80'(error_o), 80'd0);
        chk("arst_v_o", 80'(v_o), 80'd0);
        chk("arst_fsb_v", 80'(fsb_v_o), 80'd0);
        @(negedge clk);
        #2 rst = 1'b0;

`ifdef BSG_FSB_CHANNEL_MUX_CREDIT_FLUSH_EN
        inject(mk(1'b0, 1'b0, 64'h55));
        tick(); yumi_i = 2'b01;
        tick(); yumi_i = 2'b00;
        n = 0; cpkt = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (n == 0 && fsb_v_o && fsb_d_o[65]) begin n = 1; cpkt = fsb_d_o; end
        end
        chk("flush_seen", 80'(n), 80'd1);
        chk("flush_pkt", cpkt, 80'h0002_0000_0000_0000_0001);
`endif

        // three-channel instance: tag 2 is valid, tag 3 is out of range
        tick(); f3_v = 1'b1; f3_d = 80'h0002_0000_0000_0000_00AA;
        tick(); f3_v = 1'b0;
        @(negedge clk);
        chk("tag2_v_o", 80'(d3_v_o), 80'(3'b100));
        chk("tag2_err", 80'(d3_error), 80'd0);
        tick(); f3_v = 1'b1; f3_d = 80'h0003_0000_0000_0000_00BB;
        tick(); f3_v = 1'b0;
        @(negedge clk);
        chk("tag3_err", 80'(d3_error), 80'd1);
        chk("tag3_v_o", 80'(d3_v_o), 80'(3'b100));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
